// File: rtl/transmissor_quadro.sv
// Frame transmitter: snapshots the OLED framebuffer, then streams an addressing header and all data bytes over valid/ready.
// Define TRANSMISSOR_INICIALIZACAO_EN to send the SSD1306 power-up sequence once after every reset.
module transmissor_quadro #(
  parameter int unsigned N_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BYTES*8-1:0] imagem,
  input  logic                 iniciar,
  output logic                 ocupado,
  output logic                 quadro_ok,
  output logic [7:0]           dado,
  output logic                 dc,
  output logic                 valido,
  input  logic                 pronto
);

  localparam int unsigned IW_MIN = $clog2(N_BYTES + 1);
  localparam int unsigned IW     = (IW_MIN < 5) ? 5 : IW_MIN;
  localparam logic [IW-1:0] ULTIMO_DADO = IW'(N_BYTES - 1);
  localparam logic [IW-1:0] ULTIMO_CMD  = IW'(5);

`ifdef TRANSMISSOR_INICIALIZACAO_EN
  localparam logic [IW-1:0] ULTIMO_INIT = IW'(24);
  typedef enum logic [2:0] {ESPERA, CMD, DADOS, FIM, INIT} estado_t;
  localparam estado_t ESTADO_RESET = INIT;

  function automatic logic [7:0] rom_init(input logic [4:0] i);
    case (i)
      5'd0:    return 8'hAE;
      5'd1:    return 8'hD5;
      5'd2:    return 8'h80;
      5'd3:    return 8'hA8;
      5'd4:    return 8'h3F;
      5'd5:    return 8'hD3;
      5'd6:    return 8'h00;
      5'd7:    return 8'h40;
      5'd8:    return 8'h8D;
      5'd9:    return 8'h14;
      5'd10:   return 8'h20;
      5'd11:   return 8'h00;
      5'd12:   return 8'hA1;
      5'd13:   return 8'hC8;
      5'd14:   return 8'hDA;
      5'd15:   return 8'h12;
      5'd16:   return 8'h81;
      5'd17:   return 8'hCF;
      5'd18:   return 8'hD9;
      5'd19:   return 8'hF1;
      5'd20:   return 8'hDB;
      5'd21:   return 8'h40;
      5'd22:   return 8'hA4;
      5'd23:   return 8'hA6;
      5'd24:   return 8'hAF;
      default: return 8'h00;
    endcase
  endfunction
`else
  typedef enum logic [2:0] {ESPERA, CMD, DADOS, FIM} estado_t;
  localparam estado_t ESTADO_RESET = ESPERA;
`endif

  // Full column (0..127) and page (0..7) addressing window.
  function automatic logic [7:0] cabecalho(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h21;
      3'd1:    return 8'h00;
      3'd2:    return 8'h7F;
      3'd3:    return 8'h22;
      3'd4:    return 8'h00;
      3'd5:    return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

  estado_t              estado_q, estado_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pend_q, pend_d;
  logic [N_BYTES*8-1:0] snap_q, snap_d;
  logic                 carrega;

  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    carrega   = 1'b0;
    valido    = 1'b0;
    dc        = 1'b0;
    dado      = '0;
    quadro_ok = 1'b0;
    ocupado   = (estado_q != ESPERA);

    case (estado_q)
`ifdef TRANSMISSOR_INICIALIZACAO_EN
      INIT: begin
        valido = 1'b1;
        dado   = rom_init(idx_q[4:0]);
        pend_d = pend_q | iniciar;
        if (pronto) begin
          if (idx_q == ULTIMO_INIT) begin
            idx_d = '0;
            if (pend_q || iniciar) begin
              pend_d   = 1'b0;
              carrega  = 1'b1;
              estado_d = CMD;
            end else begin
              estado_d = ESPERA;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`endif
      ESPERA: begin
        idx_d = '0;
        if (iniciar) begin
          carrega  = 1'b1;
          estado_d = CMD;
        end
      end
      CMD: begin
        valido = 1'b1;
        dado   = cabecalho(idx_q[2:0]);
        pend_d = pend_q | iniciar;
        if (pronto) begin
          if (idx_q == ULTIMO_CMD) begin
            idx_d    = '0;
            estado_d = DADOS;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DADOS: begin
        valido = 1'b1;
        dc     = 1'b1;
        dado   = snap_q[{idx_q, 3'b000} +: 8];
        pend_d = pend_q | iniciar;
        if (pronto) begin
          if (idx_q == ULTIMO_DADO) begin
            idx_d    = '0;
            estado_d = FIM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FIM: begin
        quadro_ok = 1'b1;
        idx_d     = '0;
        // A request arriving in FIM itself is honoured like a pending one.
        if (pend_q || iniciar) begin
          pend_d   = 1'b0;
          carrega  = 1'b1;
          estado_d = CMD;
        end else begin
          estado_d = ESPERA;
        end
      end
      default: begin
        estado_d = ESPERA;
        idx_d    = '0;
      end
    endcase

    snap_d = carrega ? imagem : snap_q;

    // Outputs are forced low during the reset cycle so an aborted byte never handshakes.
    if (rst) begin
      valido    = 1'b0;
      dc        = 1'b0;
      dado      = '0;
      ocupado   = 1'b0;
      quadro_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ESTADO_RESET;
      idx_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_q <= snap_d;
  end

endmodule

// File: tb/tb_transmissor_quadro.sv
// Scoreboard bench for transmissor_quadro: stimulus pushes expected bytes/pulses, a monitor pops and compares.
module tb_transmissor_quadro;

  localparam int unsigned NB = 1024;
  localparam int          FRAME_LAT = 6 + NB;
  localparam logic [7:0] HDR [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  localparam logic [7:0] INIT_SEQ [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
    8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9,
    8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};

  typedef struct packed {
    logic [7:0] b;
    logic       dc;
  } item_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            iniciar = 1'b0;
  logic            pronto = 1'b1;
  logic [NB*8-1:0] imagem = '0;
  logic            ocupado, quadro_ok, dc, valido;
  logic [7:0]      dado;

  transmissor_quadro #(.N_BYTES(NB)) u_dut (
    .clk(clk), .rst(rst), .imagem(imagem), .iniciar(iniciar),
    .ocupado(ocupado), .quadro_ok(quadro_ok), .dado(dado), .dc(dc),
    .valido(valido), .pronto(pronto)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  int    edges = 0;
  int    pmode = 0;
  int    pbase = 0;
  int    xfer_count = 0;
  item_t exp_q[$];
  int    qok_q[$];

  always @(posedge clk) edges <= edges + 1;

  // pronto: 0 = always high, 1 = high on even cycles from frame start, 2 = random
  always @(posedge clk) begin
    #2;
    case (pmode)
      1:       pronto = (((edges - pbase) % 2) == 0) ? 1'b1 : 1'b0;
      2:       pronto = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      default: pronto = 1'b1;
    endcase
  end

  task automatic check(input string nome, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d", nome, act, act, req, req, edges);
    end
  endtask

  task automatic push_frame(input logic [NB*8-1:0] img);
    for (int i = 0; i < 6; i++) exp_q.push_back('{b: HDR[i], dc: 1'b0});
    for (int i = 0; i < int'(NB); i++) exp_q.push_back('{b: img[i*8 +: 8], dc: 1'b1});
  endtask

  task automatic random_image();
    for (int i = 0; i < int'(NB); i++) imagem[i*8 +: 8] = 8'($urandom);
  endtask

  // Returns n = number of the edge that sampled iniciar.
  task automatic start_frame(input int mode, output int n);
    @(posedge clk); #3;
    iniciar = 1'b1;
    @(posedge clk); #1;
    n = edges;
    iniciar = 1'b0;
    pbase = n;
    pmode = mode;
    push_frame(imagem);
    qok_q.push_back(mode == 0 ? n + FRAME_LAT : (mode == 1 ? n + 2 * FRAME_LAT - 1 : -1));
  endtask

  task automatic pulse_iniciar();
    @(posedge clk); #3;
    iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
  endtask

  task automatic wait_idle(input string nome);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || qok_q.size() != 0 || ocupado) && g < 8000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 8000) begin
      failures++;
      $display("FAIL %s_timeout: %0d bytes and %0d pulses outstanding, expected none", nome, exp_q.size(), qok_q.size());
      exp_q.delete();
      qok_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  logic       prev_stall = 1'b0;
  logic       prev_qok = 1'b0;
  logic [7:0] prev_dado = '0;
  logic       prev_dc = 1'b0;

  always @(negedge clk) begin
    item_t e;
    int    q;
    if (rst) begin
      prev_stall = 1'b0;
      prev_qok = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valido", int'(valido), 1);
        check("hold_dado", int'(dado), int'(prev_dado));
        check("hold_dc", int'(dc), int'(prev_dc));
      end
      if (prev_qok && exp_q.size() == 0 && qok_q.size() == 0)
        check("ocupado_falls", int'(ocupado), 0);
      if (valido && pronto) begin
        xfer_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_byte: got 0x%0h dc=%0d expected no transfer", dado, dc);
        end else begin
          e = exp_q.pop_front();
          check("dado", int'(dado), int'(e.b));
          check("dc", int'(dc), int'(e.dc));
        end
      end
      if (quadro_ok) begin
        check("qok_valido_low", int'(valido), 0);
        if (qok_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_quadro_ok: got pulse at edge %0d expected none", edges);
        end else begin
          q = qok_q.pop_front();
          if (q >= 0) check("qok_cycle", edges, q);
        end
      end
      prev_stall = valido && !pronto;
      prev_dado  = dado;
      prev_dc    = dc;
      prev_qok   = quadro_ok;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int g;
    int busy;
    logic [NB*8-1:0] img_b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dado", int'(dado), 0);
    check("rst_dc", int'(dc), 0);
    check("rst_valido", int'(valido), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_quadro_ok", int'(quadro_ok), 0);
`ifdef TRANSMISSOR_INICIALIZACAO_EN
    for (int i = 0; i < 25; i++) exp_q.push_back('{b: INIT_SEQ[i], dc: 1'b0});
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    wait_idle("init");

    // Ramp pattern, pronto always high.
    for (int i = 0; i < int'(NB); i++) imagem[i*8 +: 8] = 8'(i);
    start_frame(0, n);
    wait_idle("ramp");

    // Image overwritten just after the snapshot.
    random_image();
    start_frame(0, n);
    @(posedge clk); #2;
    imagem = '1;
    wait_idle("snapshot");

    // pronto toggling every cycle.
    for (int i = 0; i < int'(NB); i++) imagem[i*8 +: 8] = 8'(i) ^ 8'h5A;
    start_frame(1, n);
    wait_idle("toggle");
    pmode = 0;

    // Three requests during DADOS collapse into one back-to-back frame.
    random_image();
    start_frame(0, n);
    repeat (50) @(posedge clk);
    random_image();
    img_b = imagem;
    for (int k = 0; k < 3; k++) begin
      pulse_iniciar();
      repeat (20) @(posedge clk);
    end
    push_frame(img_b);
    qok_q.push_back(n + 2 * FRAME_LAT + 1);
    wait_idle("backtoback");

    // Reset during data byte 500 with a request pending.
    random_image();
    base = xfer_count;
    start_frame(0, n);
    repeat (30) @(posedge clk);
    pulse_iniciar();
    g = 0;
    while (xfer_count < base + 506 && g < 3000) begin
      @(posedge clk); #3;
      g++;
    end
    check("reached_byte_500", xfer_count - base, 506);
    rst = 1'b1;
    exp_q.delete();
    qok_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_dado", int'(dado), 0);
    check("abort_dc", int'(dc), 0);
    check("abort_valido", int'(valido), 0);
    check("abort_ocupado", int'(ocupado), 0);
    check("abort_quadro_ok", int'(quadro_ok), 0);
    busy = 0;
    repeat (30) begin
      @(negedge clk);
      if (ocupado || valido) busy++;
    end
    check("pending_dropped", busy, 0);

    // Random image with random pronto stalls.
    for (int k = 0; k < 2; k++) begin
      random_image();
      start_frame(2, n);
      wait_idle("random");
      pmode = 0;
    end

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/transmissor_quadro.md
# transmissor_quadro

Frame transmitter that sequences delivery of the 1024-byte OLED framebuffer to the display serializer. It sits between `controlador_imagens` (source of `imagem`) and the SPI/I2C byte serializer. On each frame request it snapshots the image to prevent tearing. It then streams an addressing command header followed by all data bytes over a valid/ready byte handshake, and signals completion.

## Interface

Parameters:
- `N_BYTES`, default 1024: framebuffer size in bytes (128×64 px, 8 pages).

Ports:
- `clk`: input, 1 bit. System clock.
- `rst`: input, 1 bit. Reset, synchronous, active-high.
- `imagem`: input, `N_BYTES*8` bits. Framebuffer; byte i = `imagem[i*8 +: 8]`.
- `iniciar`: input, 1 bit. Frame request; level sampled each cycle.
- `ocupado`: output, 1 bit. High whenever not in ESPERA.
- `quadro_ok`: output, 1 bit. One-cycle pulse when the last data byte is accepted.
- `dado`: output, 8 bits. Byte to the serializer.
- `dc`: output, 1 bit. 0 = command byte, 1 = data byte.
- `valido`: output, 1 bit. `dado`/`dc` valid.
- `pronto`: input, 1 bit. Serializer accepts the byte.

Fixed decision: one clock `clk`; reset `rst` is synchronous and active-high.

## Operation

- **States:** INIT (macro only), ESPERA, CMD, DADOS, FIM.
- **Reset:** all outputs 0 (`dado`=0x00, `dc`=0, `valido`=0, `ocupado`=0, `quadro_ok`=0), counters 0, pending flag cleared.
  - Next state is INIT if enabled, else ESPERA.
- **Handshake:**
  - A byte transfers on a rising edge with `valido`&`pronto`.
  - While `valido`&!`pronto`, `dado` and `dc` hold stable and `valido` stays high.
  - `valido` never waits on `pronto`.
- **ESPERA:**
  - If `iniciar`=1, copy `imagem` into the internal snapshot register and go to CMD.
  - Byte index resets to 0.
- **CMD:** send 6 command bytes with `dc`=0, in order: 0x21, 0x00, 0x7F, 0x22, 0x00, 0x07 (full column/page window). After the 6th transfer, go to DADOS.
- **DADOS:**
  - Send snapshot bytes 0..N_BYTES-1 in order with `dc`=1.
  - The 11-bit index increments per transfer.
  - On transfer of byte N_BYTES-1, go to FIM.
- **FIM:**
  - `quadro_ok`=1 and `valido`=0 for one cycle.
  - If the pending flag is set, clear it, take a new snapshot this cycle, and go to CMD. Otherwise go to ESPERA.
- **Pending request:**
  - `iniciar`=1 in any state other than ESPERA sets the pending flag.
  - Multiple requests collapse into one.
  - `iniciar` during FIM counts as pending.
- **Snapshot:**
  - Changes on `imagem` after the snapshot have no effect on the frame in flight.
  - The snapshot loads only in ESPERA→CMD or FIM→CMD.
- **Reset mid-frame:** abort immediately, with no `quadro_ok` pulse. The pending request is lost and the snapshot content is don't-care.

## Timing

- **Start:**
  - `iniciar` sampled high at edge N in ESPERA.
  - First command byte has `valido`=1 after edge N, i.e. in cycle N+1.
- **Throughput:** with `pronto` held high, one byte per cycle.
  - The header takes 6 cycles and the data takes N_BYTES cycles.
  - `quadro_ok` is high in cycle N+1+6+N_BYTES, i.e. cycle N+1031 for the default.
- **`ocupado`:** rises in cycle N+1 and falls the cycle after FIM if nothing is pending.
- **Back-to-back:** with a pending request, the next frame's first command byte is valid in the cycle after FIM. Frame period is 1031 cycles with no idle gap beyond FIM.
- **`pronto` stalls:** each cycle of `pronto`=0 adds exactly one cycle of latency.

## Configuration

- **`TRANSMISSOR_INICIALIZACAO_EN` defined:**
  - After reset, the FSM enters INIT with `ocupado`=1.
  - It sends the 25-byte SSD1306 power-up sequence with `dc`=0: AE D5 80 A8 3F D3 00 40 8D 14 20 00 A1 C8 DA 12 81 CF D9 F1 DB 40 A4 A6 AF.
  - It then goes to ESPERA, or straight to CMD with a snapshot if a request is pending.
  - INIT runs once per reset and does not pulse `quadro_ok`.
- **Undefined:**
  - INIT logic and the ROM are absent.
  - Reset goes directly to ESPERA and the first valid byte is a frame header.

## Test plan

1. Macro off, `pronto`=1, `imagem` byte i = i[7:0], `iniciar` pulse. Expect 21 00 7F 22 00 07 with `dc`=0, then 00 01 … FF 00 … repeating with `dc`=1, 1024 bytes total. `quadro_ok` appears exactly 1031 cycles after the sampled `iniciar`; `ocupado` then falls.
2. Change `imagem` to all 0xFF one cycle after the frame starts. Every data byte still equals the original pattern.
3. Toggle `pronto` 1/0 every cycle. `dado`/`dc` stay stable through the stalls, no byte is duplicated or skipped, and `quadro_ok` arrives at cycle N+1+2*1030-1 (last transfer + 1).
4. Pulse `iniciar` three times during DADOS. Exactly one extra frame follows, and its first header byte 0x21 is valid the cycle after `quadro_ok`.
5. Assert `rst` during data byte 500. The next cycle has all outputs 0, no `quadro_ok`, and the pending request is dropped.
6. Macro on: release reset. 25 init bytes (AE first, AF last, `dc`=0) are sent, then ESPERA; a following `iniciar` sends a normal frame.
